// File: rtl/usb_dma_arbiter.sv
// Two-port DMA arbiter sharing one 16-bit synchronous memory between USB cores.
// Grants at most one access per clock; each port runs its own IDLE/RDWAIT/ACK FSM.
module usb_dma_arbiter #(
  parameter int AW    = 15,
  parameter bit PRIO0 = 1'b0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          reqr0,
  input  logic          reqr1,
  input  logic          reqw0,
  input  logic          reqw1,
  input  logic [15:0]   dma0,
  input  logic [15:0]   dma1,
  input  logic [15:0]   dout0,
  input  logic [15:0]   dout1,
  output logic          ack0,
  output logic          ack1,
  output logic [15:0]   din0,
  output logic [15:0]   din1,
  output logic [AW-1:0] mem_addr,
  output logic          mem_rd,
  output logic          mem_wr,
  output logic [15:0]   mem_wdata,
  input  logic [15:0]   mem_rdata
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RDWAIT = 2'd1,
    ACK    = 2'd2
  } portState_e;

  logic [1:0]    reqr, reqw, elig, grant;
  logic [15:0]   dma [2];
  logic [15:0]   dout [2];
  portState_e    state_q [2];
  portState_e    state_d [2];
  logic [15:0]   din_q [2];
  logic [15:0]   din_d [2];
  logic          rrPtr_q, rrPtr_d;
  logic [AW-1:0] addr_q;
  logic [15:0]   wdata_q;
  logic          anyGrant, sel;
  logic          unusedDma;

  assign reqr    = {reqr1, reqr0};
  assign reqw    = {reqw1, reqw0};
  assign dma[0]  = dma0;
  assign dma[1]  = dma1;
  assign dout[0] = dout0;
  assign dout[1] = dout1;

  // Byte-lane bit and any bits above AW are intentionally dropped from the address.
  assign unusedDma = ^{dma[0], dma[1]};

  // rrPtr_q set means port 1 wins the next tie.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      elig[i] = (state_q[i] == IDLE) && (reqr[i] || reqw[i]);
    end
    grant[0] = elig[0] && (!elig[1] || PRIO0 || !rrPtr_q);
    grant[1] = elig[1] && !grant[0];
  end

  assign anyGrant  = |grant;
  assign sel       = grant[1];
  assign mem_wr    = anyGrant & reqw[sel];
  assign mem_rd    = anyGrant & reqr[sel] & ~reqw[sel];
  assign mem_addr  = anyGrant ? dma[sel][AW:1] : addr_q;
  assign mem_wdata = anyGrant ? dout[sel] : wdata_q;

  always_comb begin
    rrPtr_d = rrPtr_q;
    if (grant[0]) begin
      rrPtr_d = 1'b1;
    end else if (grant[1]) begin
      rrPtr_d = 1'b0;
    end
    for (int i = 0; i < 2; i++) begin
      state_d[i] = state_q[i];
      din_d[i]   = din_q[i];
      case (state_q[i])
        IDLE: begin
          if (grant[i]) begin
            state_d[i] = reqw[i] ? ACK : RDWAIT;
          end
        end
        RDWAIT: begin
          din_d[i]   = mem_rdata;
          state_d[i] = ACK;
        end
        ACK:     state_d[i] = IDLE;
        default: state_d[i] = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 2; i++) begin
        state_q[i] <= IDLE;
        din_q[i]   <= 16'h0000;
      end
      rrPtr_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= 16'h0000;
    end else begin
      for (int i = 0; i < 2; i++) begin
        state_q[i] <= state_d[i];
        din_q[i]   <= din_d[i];
      end
      rrPtr_q <= rrPtr_d;
      addr_q  <= mem_addr;
      wdata_q <= mem_wdata;
    end
  end

  assign ack0 = (state_q[0] == ACK);
  assign ack1 = (state_q[1] == ACK);
  assign din0 = din_q[0];
  assign din1 = din_q[1];

endmodule

// File: tb/tb_usb_dma_arbiter.sv
// Directed bench for usb_dma_arbiter: a round-robin and a fixed-priority instance
// share the same requester inputs, each with its own synchronous memory model.
module tb_usb_dma_arbiter;

  logic        clk;
  logic        reset;
  logic        reqr0, reqr1, reqw0, reqw1;
  logic [15:0] dma0, dma1, dout0, dout1;

  logic        ack0R, ack1R, memRdR, memWrR;
  logic [15:0] din0R, din1R, memWdataR, memRdataR;
  logic [14:0] memAddrR;
  logic        ack0F, ack1F, memRdF, memWrF;
  logic [15:0] din0F, din1F, memWdataF, memRdataF;
  logic [14:0] memAddrF;

  logic [15:0] memR [0:32767];
  logic [15:0] memF [0:32767];

  int errors = 0;
  int checks = 0;

  // Per-cycle expectations for the mixed contention run: 0 = port0 write, 1 = port1 read, 2 = idle.
  int fpCode [6] = '{0, 1, 0, 2, 0, 1};
  int rrCode [6] = '{0, 1, 0, 2, 1, 0};
  int fpAck  [6] = '{0, 1, 0, 3, 0, 1};
  int rrAck  [6] = '{0, 1, 0, 3, 0, 0};

  usb_dma_arbiter #(.AW(15), .PRIO0(1'b0)) dutRr (
    .clk(clk), .reset(reset),
    .reqr0(reqr0), .reqr1(reqr1), .reqw0(reqw0), .reqw1(reqw1),
    .dma0(dma0), .dma1(dma1), .dout0(dout0), .dout1(dout1),
    .ack0(ack0R), .ack1(ack1R), .din0(din0R), .din1(din1R),
    .mem_addr(memAddrR), .mem_rd(memRdR), .mem_wr(memWrR),
    .mem_wdata(memWdataR), .mem_rdata(memRdataR)
  );

  usb_dma_arbiter #(.AW(15), .PRIO0(1'b1)) dutFp (
    .clk(clk), .reset(reset),
    .reqr0(reqr0), .reqr1(reqr1), .reqw0(reqw0), .reqw1(reqw1),
    .dma0(dma0), .dma1(dma1), .dout0(dout0), .dout1(dout1),
    .ack0(ack0F), .ack1(ack1F), .din0(din0F), .din1(din1F),
    .mem_addr(memAddrF), .mem_rd(memRdF), .mem_wr(memWrF),
    .mem_wdata(memWdataF), .mem_rdata(memRdataF)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory models: a few known words are (re)loaded while reset is asserted.
  always @(posedge clk) begin
    if (!reset) begin
      memR[15'h2B3C] <= 16'h9ABC;
      memR[15'h0100] <= 16'hCAFE;
      memF[15'h2B3C] <= 16'h9ABC;
      memF[15'h0100] <= 16'hCAFE;
    end else begin
      if (memWrR) memR[memAddrR] <= memWdataR;
      if (memRdR) memRdataR <= memR[memAddrR];
      if (memWrF) memF[memAddrF] <= memWdataF;
      if (memRdF) memRdataF <= memF[memAddrF];
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic r0, input logic w0, input logic r1, input logic w1);
    reqr0 = r0;
    reqw0 = w0;
    reqr1 = r1;
    reqw1 = w1;
  endtask

  task automatic toNeg();
    @(negedge clk);
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    advance();
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    dma0 = 16'h0000; dma1 = 16'h0000; dout0 = 16'h0000; dout1 = 16'h0000;
    repeat (2) @(posedge clk);
    #1;
    toNeg();
    checkOutput("rst_ack0", 16'(ack0R), 16'h0);
    checkOutput("rst_ack1", 16'(ack1R), 16'h0);
    checkOutput("rst_din0", din0R, 16'h0000);
    checkOutput("rst_din1", din1R, 16'h0000);
    checkOutput("rst_memwr", 16'(memWrR), 16'h0);
    checkOutput("rst_memrd", 16'(memRdR), 16'h0);
    advance();
    reset = 1'b1;

    $display("[TB] single write on port 0");
    dma0 = 16'h2000; dout0 = 16'h1234;
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    toNeg();
    checkOutput("wr_memwr", 16'(memWrR), 16'h1);
    checkOutput("wr_memrd", 16'(memRdR), 16'h0);
    checkOutput("wr_addr", 16'(memAddrR), 16'h1000);
    checkOutput("wr_wdata", memWdataR, 16'h1234);
    checkOutput("wr_ack0_T", 16'(ack0R), 16'h0);
    advance();
    toNeg();
    checkOutput("wr_ack0_T1", 16'(ack0R), 16'h1);
    checkOutput("wr_no_regrant", 16'(memWrR), 16'h0);
    advance();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    toNeg();
    checkOutput("wr_ack0_T2", 16'(ack0R), 16'h0);
    checkOutput("wr_din0_kept", din0R, 16'h0000);
    advance();

    $display("[TB] single read on port 1");
    dma1 = 16'h5678;
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    toNeg();
    checkOutput("rd_memrd", 16'(memRdR), 16'h1);
    checkOutput("rd_memwr", 16'(memWrR), 16'h0);
    checkOutput("rd_addr", 16'(memAddrR), 16'h2B3C);
    advance();
    toNeg();
    checkOutput("rd_ack1_T1", 16'(ack1R), 16'h0);
    checkOutput("rd_memrd_T1", 16'(memRdR), 16'h0);
    advance();
    toNeg();
    checkOutput("rd_ack1_T2", 16'(ack1R), 16'h1);
    checkOutput("rd_din1", din1R, 16'h9ABC);
    checkOutput("rd_din0_kept", din0R, 16'h0000);
    advance();
    dma0 = 16'h2001;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    toNeg();
    checkOutput("rd_ack1_T3", 16'(ack1R), 16'h0);
    checkOutput("rd_din1_held", din1R, 16'h9ABC);
    checkOutput("rd0_addr_bit0", 16'(memAddrR), 16'h1000);
    checkOutput("rd0_memrd", 16'(memRdR), 16'h1);
    advance();
    advance();
    toNeg();
    checkOutput("rd0_ack0", 16'(ack0R), 16'h1);
    checkOutput("rd0_din0", din0R, 16'h1234);
    advance();

    $display("[TB] round-robin tie after a port 0 grant");
    dma0 = 16'h0100; dma1 = 16'h0400; dout0 = 16'hAAAA; dout1 = 16'h5555;
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
    toNeg();
    checkOutput("rr_tie_addr", 16'(memAddrR), 16'h0200);
    checkOutput("rr_tie_wdata", memWdataR, 16'h5555);
    checkOutput("fp_tie_addr", 16'(memAddrF), 16'h0080);
    advance();
    toNeg();
    checkOutput("rr_tie_ack1", 16'(ack1R), 16'h1);
    checkOutput("rr_next_addr", 16'(memAddrR), 16'h0080);
    checkOutput("rr_next_wdata", memWdataR, 16'hAAAA);
    checkOutput("rr_next_wr", 16'(memWrR), 16'h1);
    advance();
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    toNeg();
    checkOutput("rr_next_ack0", 16'(ack0R), 16'h1);
    checkOutput("rr_next_ack1", 16'(ack1R), 16'h0);
    checkOutput("rr_ackcyc_wr", 16'(memWrR), 16'h0);
    advance();

    $display("[TB] round-robin write contention");
    doReset();
    dma0 = 16'h0100; dma1 = 16'h0400;
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
    for (int c = 0; c < 6; c++) begin
      toNeg();
      checkOutput("alt_wr", 16'(memWrR), 16'h1);
      checkOutput("alt_addr", 16'(memAddrR), (c % 2 == 0) ? 16'h0080 : 16'h0200);
      checkOutput("alt_ack0", 16'(ack0R), (c % 2 == 1) ? 16'h1 : 16'h0);
      checkOutput("alt_ack1", 16'(ack1R), (c > 0 && c % 2 == 0) ? 16'h1 : 16'h0);
      advance();
    end

    $display("[TB] mixed contention, round-robin vs fixed priority");
    doReset();
    dma0 = 16'h0100; dma1 = 16'h0200; dout0 = 16'hBEEF;
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
    for (int c = 0; c < 6; c++) begin
      toNeg();
      checkOutput("fp_wr", 16'(memWrF), (fpCode[c] == 0) ? 16'h1 : 16'h0);
      checkOutput("fp_rd", 16'(memRdF), (fpCode[c] == 1) ? 16'h1 : 16'h0);
      if (fpCode[c] != 2) begin
        checkOutput("fp_addr", 16'(memAddrF), (fpCode[c] == 0) ? 16'h0080 : 16'h0100);
      end
      checkOutput("fp_acks", {14'h0, ack1F, ack0F}, 16'(fpAck[c]));
      checkOutput("rr_wr", 16'(memWrR), (rrCode[c] == 0) ? 16'h1 : 16'h0);
      checkOutput("rr_rd", 16'(memRdR), (rrCode[c] == 1) ? 16'h1 : 16'h0);
      if (rrCode[c] != 2) begin
        checkOutput("rr_addr", 16'(memAddrR), (rrCode[c] == 0) ? 16'h0080 : 16'h0100);
      end
      checkOutput("rr_acks", {14'h0, ack1R, ack0R}, 16'(rrAck[c]));
      if (c == 3) begin
        checkOutput("fp_din1", din1F, 16'hCAFE);
        checkOutput("rr_din1", din1R, 16'hCAFE);
      end
      advance();
    end

    $display("[TB] same-port read held through ack");
    doReset();
    dma0 = 16'h2001;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    toNeg();
    checkOutput("b2b_rd_T", 16'(memRdR), 16'h1);
    checkOutput("b2b_addr", 16'(memAddrR), 16'h1000);
    advance();
    toNeg();
    checkOutput("b2b_rd_T1", 16'(memRdR), 16'h0);
    checkOutput("b2b_ack_T1", 16'(ack0R), 16'h0);
    advance();
    toNeg();
    checkOutput("b2b_ack_T2", 16'(ack0R), 16'h1);
    checkOutput("b2b_din0", din0R, 16'h1234);
    checkOutput("b2b_rd_T2", 16'(memRdR), 16'h0);
    advance();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    toNeg();
    checkOutput("b2b_ack_T3", 16'(ack0R), 16'h0);
    checkOutput("b2b_rd_T3", 16'(memRdR), 16'h0);
    advance();

    $display("[TB] reset during read wait");
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    toNeg();
    checkOutput("mr_rd_T", 16'(memRdR), 16'h1);
    advance();
    reset = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    toNeg();
    checkOutput("mr_ack_wait", 16'(ack0R), 16'h0);
    advance();
    reset = 1'b1;
    toNeg();
    checkOutput("mr_ack_after", 16'(ack0R), 16'h0);
    checkOutput("mr_din0_clr", din0R, 16'h0000);
    advance();
    toNeg();
    checkOutput("mr_ack_later", 16'(ack0R), 16'h0);
    checkOutput("mr_din0_later", din0R, 16'h0000);
    advance();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    toNeg();
    checkOutput("mr_new_rd", 16'(memRdR), 16'h1);
    checkOutput("mr_new_addr", 16'(memAddrR), 16'h1000);
    advance();
    toNeg();
    checkOutput("mr_new_ack_T1", 16'(ack0R), 16'h0);
    advance();
    toNeg();
    checkOutput("mr_new_ack_T2", 16'(ack0R), 16'h1);
    checkOutput("mr_new_din0", din0R, 16'h1234);
    advance();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    toNeg();
    checkOutput("mr_new_ack_T3", 16'(ack0R), 16'h0);
    advance();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
